frame_stop_trigger: RTL and testbench

//  Initiator side of the frame-stop handshake. Counts detector-flagged pixels (pixel_match)
//  in each active 640x480 frame. After CONSEC_FRAMES consecutive frames reach THRESHOLD,

---
 rtl/frame_stop_trigger.sv | 161 ++++++++++++++++
 tb/tb_frame_stop_trigger.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stop_trigger.sv
// frame_stop_trigger: initiator side of the frame-stop handshake.
// Counts detector-flagged pixels per active frame. After CONSEC_FRAMES
// consecutive frames reach THRESHOLD it issues a one-clock stop request,
// follows the holder's busy flag, then waits out a cooldown before re-arming.
//
// Handshake: f2s_en is a single-clock request pulse, not a valid/ready pair.
// The holder acknowledges by raising f2s_busy and keeps it high for as long
// as it holds the frame. A request that sees no f2s_busy within ACK_TIMEOUT
// frame ends is treated as lost and is not retried. f2s_busy is ignored
// outside WAIT_ACK and BUSY.
module frame_stop_trigger #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int CNT_W           = 19,
    parameter int THRESHOLD       = 2000,
    parameter int CONSEC_FRAMES   = 3,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int ACK_TIMEOUT     = 2
) (
    input  logic             vga_pclk,
    input  logic             reset,
    input  logic [9:0]       x_pixel,
    input  logic [9:0]       y_pixel,
    input  logic             pixel_match,
    input  logic             arm,
    input  logic             f2s_busy,
    output logic             f2s_en,
    output logic [CNT_W-1:0] last_frame_cnt,
    output logic [2:0]       hit_streak,
    output logic             det_led,
    output logic [2:0]       state_dbg
);

    localparam int TMR_MAX = (COOLDOWN_FRAMES > ACK_TIMEOUT) ? COOLDOWN_FRAMES : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACCUM    = 3'd1,
        FIRE     = 3'd2,
        WAIT_ACK = 3'd3,
        BUSY     = 3'd4,
        COOLDOWN = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               yen;
    logic               yen_q;
    logic               frame_start;
    logic               frame_end;
    logic               armed_frame;
    logic               arming;
    logic               count_pix;
    logic               frame_done;
    logic               hit;
    logic [2:0]         streak_inc;
    logic [2:0]         new_streak;
    logic [CNT_W-1:0]   cur_cnt;
    logic [TMR_W-1:0]   tmr;

    assign state_dbg = state;
    assign det_led   = (state == BUSY) || (state == COOLDOWN);

    // Frame edge detection and per-pixel qualification
    always_comb begin
        yen         = (y_pixel < 10'(V_ACTIVE));
        frame_start = yen && !yen_q;
        frame_end   = !yen && yen_q;
        // The pixel on the frame_start clock belongs to the new frame, so it
        // counts even though armed_frame only rises after this edge.
        arming      = (state == ACCUM) && arm && frame_start;
        count_pix   = (armed_frame || arming) && yen &&
                      (x_pixel < 10'(H_ACTIVE)) && pixel_match;
        frame_done  = (state == ACCUM) && arm && armed_frame && frame_end;
        hit         = (cur_cnt >= CNT_W'(THRESHOLD));
        streak_inc  = (hit_streak >= 3'(CONSEC_FRAMES)) ? 3'(CONSEC_FRAMES)
                                                        : hit_streak + 3'd1;
        new_streak  = hit ? streak_inc : 3'd0;
    end

    // Next-state logic; dropping arm wins over every other transition
    always_comb begin
        next_state = state;
        if (!arm) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     next_state = ACCUM;
                ACCUM:    if (frame_done && (new_streak == 3'(CONSEC_FRAMES))) next_state = FIRE;
                FIRE:     next_state = WAIT_ACK;
                WAIT_ACK: begin
                    if (f2s_busy)                                             next_state = BUSY;
                    else if (frame_end && (tmr == TMR_W'(ACK_TIMEOUT - 1)))   next_state = ACCUM;
                end
                BUSY:     if (!f2s_busy) next_state = COOLDOWN;
                COOLDOWN: if (frame_end && (tmr == TMR_W'(COOLDOWN_FRAMES - 1))) next_state = ACCUM;
                default:  next_state = IDLE;
            endcase
        end
    end

    // State register and registered request pulse (high only while in FIRE)
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            f2s_en <= 1'b0;
            yen_q  <= 1'b0;
        end else begin
            state  <= next_state;
            f2s_en <= (next_state == FIRE);
            yen_q  <= yen;
        end
    end

    // Frame arming: only frames that start while accumulating are counted
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset)                           armed_frame <= 1'b0;
        else if (!arm || (state != ACCUM))   armed_frame <= 1'b0;
        else if (frame_start)                armed_frame <= 1'b1;
        else if (frame_end)                  armed_frame <= 1'b0;
    end

    // Per-frame match counter, saturating, held at zero outside ACCUM
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset)                               cur_cnt <= '0;
        else if (!arm || (state != ACCUM))       cur_cnt <= '0;
        else if (frame_done)                     cur_cnt <= '0;
        else if (count_pix && (cur_cnt != '1))   cur_cnt <= cur_cnt + CNT_W'(1);
    end

    // Completed-frame count; survives arm dropping
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset)           last_frame_cnt <= '0;
        else if (frame_done) last_frame_cnt <= cur_cnt;
    end

    // Consecutive-hit streak; cleared once the request has been issued
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset)               hit_streak <= 3'd0;
        else if (!arm)           hit_streak <= 3'd0;
        else if (state == FIRE)  hit_streak <= 3'd0;
        else if (frame_done)     hit_streak <= new_streak;
    end

    // Frame-end timer shared by the ack timeout and the cooldown
    always_ff @(posedge vga_pclk or posedge reset) begin
        if (reset) begin
            tmr <= '0;
        end else if (!arm) begin
            tmr <= '0;
        end else begin
            case (state)
                WAIT_ACK, COOLDOWN: if (frame_end) tmr <= tmr + TMR_W'(1);
                BUSY:               tmr <= '0;
                default:            tmr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stop_trigger.sv
// tb_frame_stop_trigger: directed frame-level vectors for frame_stop_trigger.
// Frames are compressed: the active region is only as many pixel clocks as a
// test needs, followed by a short vertical blank at y = 480.
module tb_frame_stop_trigger;

    localparam int CNT_W = 19;

    localparam int M_N = 0;  // matches inside the active area
    localparam int M_X = 1;  // matches at x >= 640 inside active lines
    localparam int M_Y = 2;  // matches in the blank (y >= 480) before the frame

    localparam int S_IDLE     = 0;
    localparam int S_ACCUM    = 1;
    localparam int S_FIRE     = 2;
    localparam int S_WAIT_ACK = 3;
    localparam int S_BUSY     = 4;
    localparam int S_COOLDOWN = 5;

    typedef struct {
        int mode;
        int n_act;
        int n_match;
        int exp_cnt;
        int exp_streak;
        int exp_en;
        int exp_state;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic             vga_pclk = 1'b0;
    logic             reset;
    logic [9:0]       x_pixel;
    logic [9:0]       y_pixel;
    logic             pixel_match;
    logic             arm;
    logic             f2s_busy;
    logic             f2s_en;
    logic [CNT_W-1:0] last_frame_cnt;
    logic [2:0]       hit_streak;
    logic             det_led;
    logic [2:0]       state_dbg;

    always #5 vga_pclk = ~vga_pclk;

    frame_stop_trigger dut (
        .vga_pclk       (vga_pclk),
        .reset          (reset),
        .x_pixel        (x_pixel),
        .y_pixel        (y_pixel),
        .pixel_match    (pixel_match),
        .arm            (arm),
        .f2s_busy       (f2s_busy),
        .f2s_en         (f2s_en),
        .last_frame_cnt (last_frame_cnt),
        .hit_streak     (hit_streak),
        .det_led        (det_led),
        .state_dbg      (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int               total = 0;
    int               bad   = 0;
    int               pulses = 0;
    logic [CNT_W-1:0] exp_q[$];
    vec_t             tbl[16];

    logic [31:0] s_en, s_cnt, s_streak, s_state, s_led;

    always @(negedge vga_pclk) if (f2s_en === 1'b1) pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at a negedge; on return the next negedge has arrived and
    // the outputs reflect the posedge that consumed them.
    task automatic step(input int x, input int y, input logic m);
        x_pixel     = 10'(x);
        y_pixel     = 10'(y);
        pixel_match = m;
        @(negedge vga_pclk);
    endtask

    task automatic active(input int mode, input int n, input int nm);
        for (int i = 0; i < n; i++) begin
            if (mode == M_X) step(640 + i % 384, i / 384, (i < nm));
            else             step(i % 640, i / 640, (i < nm));
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) step(0, 480, 1'b0);
    endtask

    task automatic end_edge();
        step(0, 480, 1'b0);
        s_en     = 32'(f2s_en);
        s_cnt    = 32'(last_frame_cnt);
        s_streak = 32'(hit_streak);
        s_state  = 32'(state_dbg);
        s_led    = 32'(det_led);
    endtask

    task automatic do_frame(input int mode, input int n_act, input int n_match);
        if (mode == M_Y) begin
            for (int i = 0; i < n_match; i++) step(0, 480 + i % 544, 1'b1);
            active(mode, n_act, 0);
        end else begin
            active(mode, n_act, n_match);
        end
        end_edge();
        blank(3);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0;
        int p1;
        logic [CNT_W-1:0] e;

        tbl[0]  = '{M_N, 2600, 2500, 2500, 1, 0, S_ACCUM};
        tbl[1]  = '{M_N, 2600, 2500, 2500, 2, 0, S_ACCUM};
        tbl[2]  = '{M_N, 2600, 2500, 2500, 3, 1, S_FIRE};
        tbl[3]  = '{M_N,   20,   20, 2500, 0, 0, S_WAIT_ACK};
        tbl[4]  = '{M_N,   20,   20, 2500, 0, 0, S_ACCUM};
        tbl[5]  = '{M_N, 2600, 2500, 2500, 1, 0, S_ACCUM};
        tbl[6]  = '{M_N, 2600, 1999, 1999, 0, 0, S_ACCUM};
        tbl[7]  = '{M_N, 2600, 2500, 2500, 1, 0, S_ACCUM};
        tbl[8]  = '{M_N, 2600, 2500, 2500, 2, 0, S_ACCUM};
        tbl[9]  = '{M_N, 2600, 2500, 2500, 3, 1, S_FIRE};
        tbl[10] = '{M_N,   20,    0, 2500, 0, 0, S_WAIT_ACK};
        tbl[11] = '{M_N,   20,    0, 2500, 0, 0, S_ACCUM};
        tbl[12] = '{M_X,  400,  400,    0, 0, 0, S_ACCUM};
        tbl[13] = '{M_Y,   20,  300,    0, 0, 0, S_ACCUM};
        tbl[14] = '{M_N, 2600, 2000, 2000, 1, 0, S_ACCUM};
        tbl[15] = '{M_N,   20,    0,    0, 0, 0, S_ACCUM};

        reset = 1'b1; arm = 1'b0; f2s_busy = 1'b0;
        x_pixel = '0; y_pixel = 10'd480; pixel_match = 1'b0;
        @(negedge vga_pclk);

        // T1: reset held with random inputs
        for (int i = 0; i < 20; i++) begin
            x_pixel     = 10'($urandom_range(0, 1023));
            y_pixel     = 10'($urandom_range(0, 1023));
            pixel_match = 1'($urandom_range(0, 1));
            arm         = 1'($urandom_range(0, 1));
            f2s_busy    = 1'($urandom_range(0, 1));
            @(negedge vga_pclk);
            if (i % 5 == 4) begin
                check("rst f2s_en", 32'(f2s_en), 0);
                check("rst last_cnt", 32'(last_frame_cnt), 0);
                check("rst streak", 32'(hit_streak), 0);
                check("rst det_led", 32'(det_led), 0);
            end
        end
        arm = 1'b0; f2s_busy = 1'b0;
        blank(1);
        reset = 1'b0;
        blank(2);
        check("idle after reset", 32'(state_dbg), S_IDLE);
        arm = 1'b1;
        blank(2);
        check("accum after arm", 32'(state_dbg), S_ACCUM);

        // T2, T3, T4, ack timeout, threshold boundary: table-driven frames
        p0 = pulses;
        for (int r = 0; r < 16; r++) begin
            exp_q.push_back(CNT_W'(tbl[r].exp_cnt));
            do_frame(tbl[r].mode, tbl[r].n_act, tbl[r].n_match);
            e = exp_q.pop_front();
            check($sformatf("row%0d cnt", r),    s_cnt,    32'(e));
            check($sformatf("row%0d streak", r), s_streak, 32'(tbl[r].exp_streak));
            check($sformatf("row%0d en", r),     s_en,     32'(tbl[r].exp_en));
            check($sformatf("row%0d state", r),  s_state,  32'(tbl[r].exp_state));
        end
        check("table pulse count", 32'(pulses - p0), 2);

        // T5: busy for 230 frames, 60-frame cooldown, then 3 more hits
        p0 = pulses;
        do_frame(M_N, 2600, 2500);
        check("t5 streak1", s_streak, 1);
        do_frame(M_N, 2600, 2500);
        check("t5 streak2", s_streak, 2);
        active(M_N, 2600, 2500);
        end_edge();
        check("t5 fire en", s_en, 1);
        f2s_busy = 1'b1;
        blank(1);
        check("t5 wait_ack", 32'(state_dbg), S_WAIT_ACK);
        check("t5 en one clock", 32'(f2s_en), 0);
        blank(1);
        check("t5 busy at once", 32'(state_dbg), S_BUSY);
        for (int f = 0; f < 230; f++) begin
            do_frame(M_N, 8, 8);
            check($sformatf("t5 busy led f%0d", f), s_led, 1);
            check($sformatf("t5 busy state f%0d", f), s_state, S_BUSY);
        end
        f2s_busy = 1'b0;
        blank(1);
        check("t5 cooldown entry", 32'(state_dbg), S_COOLDOWN);
        for (int f = 1; f <= 60; f++) begin
            do_frame(M_N, 8, 8);
            check($sformatf("t5 cool state f%0d", f), s_state, (f < 60) ? S_COOLDOWN : S_ACCUM);
            check($sformatf("t5 cool led f%0d", f), s_led, (f < 60) ? 1 : 0);
        end
        check("t5 no pulse while busy", 32'(pulses - p0), 1);
        do_frame(M_N, 2600, 2500);
        check("t5 re streak1", s_streak, 1);
        check("t5 re en1", s_en, 0);
        do_frame(M_N, 2600, 2500);
        check("t5 re streak2", s_streak, 2);
        check("t5 re en2", s_en, 0);
        do_frame(M_N, 2600, 2500);
        check("t5 re fire", s_en, 1);
        check("t5 pulse count", 32'(pulses - p0), 2);
        do_frame(M_N, 20, 0);
        do_frame(M_N, 20, 0);
        check("t5 timeout accum", s_state, S_ACCUM);

        // T6: arm dropped mid-frame
        p0 = pulses;
        do_frame(M_N, 2600, 2500);
        do_frame(M_N, 2600, 2500);
        check("t6 streak2", s_streak, 2);
        active(M_N, 1300, 1300);
        arm = 1'b0;
        step(0, 3, 1'b1);
        check("t6 idle next clock", 32'(state_dbg), S_IDLE);
        check("t6 streak cleared", 32'(hit_streak), 0);
        active(M_N, 1300, 1300);
        end_edge();
        check("t6 drop en", s_en, 0);
        check("t6 drop cnt held", s_cnt, 2500);
        check("t6 drop state", s_state, S_IDLE);
        check("t6 drop pulses", 32'(pulses - p0), 0);
        arm = 1'b1;
        blank(2);
        check("t6 rearm", 32'(state_dbg), S_ACCUM);

        // T6: reset during FIRE
        do_frame(M_N, 2600, 2500);
        do_frame(M_N, 2600, 2500);
        active(M_N, 2600, 2500);
        end_edge();
        check("t6 fire before reset", s_en, 1);
        #1 reset = 1'b1;
        #1;
        check("t6 reset en", 32'(f2s_en), 0);
        check("t6 reset state", 32'(state_dbg), S_IDLE);
        check("t6 reset cnt", 32'(last_frame_cnt), 0);
        check("t6 reset streak", 32'(hit_streak), 0);
        blank(3);
        reset = 1'b0;
        p1 = pulses;
        blank(20);
        check("t6 no pulse after release", 32'(pulses - p1), 0);
        check("t6 accum after release", 32'(state_dbg), S_ACCUM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
